ns_input_interpolator: RTL



---
 rtl/ns_pkg.sv | 23 ++
 rtl/ns_strobe_gen.sv | 46 ++++
 rtl/ns_input_interpolator.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/ns_pkg.sv
// ----------------------------------------------------------------------------
// ns_pkg
// Shared constants and types for the noise-shaper front end.
//   NS_DATA_W      : sample width at the noise-shaper input
//   NS_CLK_DIV     : CLK_24M cycles per enable_3M strobe
//   NS_INTERP_LOG2 : log2 of the 48 kHz -> 3.072 MHz interpolation factor
//   ns_sample_t    : signed sample handed to the shaper
//   ns_interp_state_e : interpolator control states
// ----------------------------------------------------------------------------
package ns_pkg;

    localparam int NS_DATA_W      = 11;
    localparam int NS_CLK_DIV     = 8;
    localparam int NS_INTERP_LOG2 = 6;

    typedef logic signed [NS_DATA_W-1:0] ns_sample_t;

    typedef enum logic {
        FILL = 1'b0,
        RUN  = 1'b1
    } ns_interp_state_e;

endpackage

// File: rtl/ns_strobe_gen.sv
// ----------------------------------------------------------------------------
// ns_strobe_gen
// Divides CLK_24M down to a registered one-cycle enable strobe.
// Ports:
//   CLK_24M   in  system clock
//   reset     in  asynchronous, active-low
//   enable_3M out high for exactly the cycle in which the divider sits at
//                 CLK_DIV-1, i.e. one cycle in every CLK_DIV
// ----------------------------------------------------------------------------
module ns_strobe_gen #(
    parameter int CLK_DIV = 8
) (
    input  logic CLK_24M,
    input  logic reset,
    output logic enable_3M
);

    localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] div_cnt_q, div_cnt_d;
    logic             enable_3M_q, enable_3M_d;

    // The strobe is derived from the next count so that the registered
    // strobe lines up with the cycle where the counter holds CNT_LAST.
    always_comb begin
        div_cnt_d = div_cnt_q + 1'b1;
        if (div_cnt_q == CNT_LAST) begin
            div_cnt_d = '0;
        end
        enable_3M_d = (div_cnt_d == CNT_LAST);
    end

    always_ff @(posedge CLK_24M or negedge reset) begin
        if (!reset) begin
            div_cnt_q   <= '0;
            enable_3M_q <= 1'b0;
        end else begin
            div_cnt_q   <= div_cnt_d;
            enable_3M_q <= enable_3M_d;
        end
    end

    assign enable_3M = enable_3M_q;

endmodule

// File: rtl/ns_input_interpolator.sv
// ----------------------------------------------------------------------------
// ns_input_interpolator
// Feeds the fifth-order noise shaper: takes low-rate signed PCM over a
// valid/ready handshake, linearly interpolates by 2^INTERP_LOG2, then rounds
// and saturates each point to the shaper's OUT_W-bit input. Also generates
// the enable_3M strobe shared with the shaper.
// Optional build macro NS_INTERP_DITHER_EN: replaces the round-half-up
// constant with the low SH bits of a 16-bit LFSR (rectangular dither).
// Ports:
//   CLK_24M        in  system clock
//   reset          in  asynchronous, active-low
//   in_data        in  signed PCM sample
//   in_valid       in  in_data is valid
//   in_ready       out one-entry buffer is empty
//   clear_underrun in  synchronous clear of the underrun flag
//   enable_3M      out one-cycle strobe every CLK_DIV cycles
//   data_o         out signed sample to the shaper, changes only on strobes
//   underrun       out sticky: a sample was needed but none was buffered
// ----------------------------------------------------------------------------
module ns_input_interpolator
    import ns_pkg::*;
#(
    parameter int IN_W        = 16,
    parameter int OUT_W       = NS_DATA_W,
    parameter int INTERP_LOG2 = NS_INTERP_LOG2,
    parameter int CLK_DIV     = NS_CLK_DIV
) (
    input  logic                    CLK_24M,
    input  logic                    reset,
    input  logic signed [IN_W-1:0]  in_data,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    clear_underrun,
    output logic                    enable_3M,
    output logic signed [OUT_W-1:0] data_o,
    output logic                    underrun
);

    localparam int SH = IN_W - OUT_W;
    localparam int PW = IN_W + INTERP_LOG2 + 2;
    localparam logic signed [OUT_W:0] SAT_MAX = (OUT_W+1)'((2**(OUT_W-1)) - 1);
    localparam logic signed [OUT_W:0] SAT_MIN = (OUT_W+1)'(-(2**(OUT_W-1)));
`ifndef NS_INTERP_DITHER_EN
    localparam logic signed [IN_W:0]  ROUND_C = (IN_W+1)'(2**(SH-1));
`endif

    ns_interp_state_e         state_q, state_d;
    logic signed [IN_W-1:0]   buf_q, buf_d;
    logic                     buf_full_q, buf_full_d;
    logic signed [IN_W-1:0]   prev_q, prev_d;
    logic signed [IN_W-1:0]   curr_q, curr_d;
    logic [INTERP_LOG2-1:0]   phase_q, phase_d;
    logic signed [OUT_W-1:0]  data_o_q, data_o_d;
    logic                     underrun_q, underrun_d;

    logic signed [IN_W:0]     diff, interp, round_c, rounded;
    logic signed [PW-1:0]     diff_ext, phase_ext, prod;
    logic signed [OUT_W:0]    out_full;
    logic signed [OUT_W-1:0]  sat_val;

    ns_strobe_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_strobe (
        .CLK_24M   (CLK_24M),
        .reset     (reset),
        .enable_3M (enable_3M)
    );

`ifdef NS_INTERP_DITHER_EN
    logic [15:0] lfsr_q, lfsr_d;

    // Fibonacci LFSR, taps 16,15,13,4; steps once per 3M period.
    always_comb begin
        lfsr_d = lfsr_q;
        if (enable_3M) begin
            lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[14] ^ lfsr_q[12] ^ lfsr_q[3]};
        end
    end

    always_ff @(posedge CLK_24M or negedge reset) begin
        if (!reset) begin
            lfsr_q <= 16'hACE1;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end
`endif

    // Interpolation point from the current (pre-update) prev/curr/phase.
    // interp always lies between prev and curr, so IN_W+1 bits never wrap.
    always_comb begin
        diff      = {curr_q[IN_W-1], curr_q} - {prev_q[IN_W-1], prev_q};
        diff_ext  = $signed({{(PW-IN_W-1){diff[IN_W]}}, diff});
        phase_ext = $signed({{(PW-INTERP_LOG2){1'b0}}, phase_q});
        prod      = diff_ext * phase_ext;
        interp    = (IN_W+1)'($signed({{(PW-IN_W){prev_q[IN_W-1]}}, prev_q}) + (prod >>> INTERP_LOG2));
`ifdef NS_INTERP_DITHER_EN
        round_c   = $signed({{(IN_W+1-SH){1'b0}}, lfsr_q[SH-1:0]});
`else
        round_c   = ROUND_C;
`endif
        rounded   = interp + round_c;
        out_full  = (OUT_W+1)'(rounded >>> SH);
        sat_val   = out_full[OUT_W-1:0];
        if (out_full > SAT_MAX) begin
            sat_val = SAT_MAX[OUT_W-1:0];
        end else if (out_full < SAT_MIN) begin
            sat_val = SAT_MIN[OUT_W-1:0];
        end
    end

    // Buffer accept runs every cycle; everything else advances only on
    // strobe edges. Consume and accept never coincide because in_ready is
    // low whenever the buffer holds a sample. The underrun set is applied
    // after the clear so a simultaneous set wins.
    always_comb begin
        state_d    = state_q;
        buf_d      = buf_q;
        buf_full_d = buf_full_q;
        prev_d     = prev_q;
        curr_d     = curr_q;
        phase_d    = phase_q;
        data_o_d   = data_o_q;
        underrun_d = underrun_q;

        if (in_valid && !buf_full_q) begin
            buf_d      = in_data;
            buf_full_d = 1'b1;
        end

        if (clear_underrun) begin
            underrun_d = 1'b0;
        end

        if (enable_3M) begin
            case (state_q)
                FILL: begin
                    data_o_d = '0;
                    if (buf_full_q) begin
                        curr_d     = buf_q;
                        prev_d     = '0;
                        phase_d    = '0;
                        buf_full_d = 1'b0;
                        state_d    = RUN;
                    end
                end
                RUN: begin
                    data_o_d = sat_val;
                    phase_d  = phase_q + 1'b1;
                    if (phase_q == '1) begin
                        prev_d = curr_q;
                        if (buf_full_q) begin
                            curr_d     = buf_q;
                            buf_full_d = 1'b0;
                        end else begin
                            underrun_d = 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = FILL;
                end
            endcase
        end
    end

    always_ff @(posedge CLK_24M or negedge reset) begin
        if (!reset) begin
            state_q    <= FILL;
            buf_q      <= '0;
            buf_full_q <= 1'b0;
            prev_q     <= '0;
            curr_q     <= '0;
            phase_q    <= '0;
            data_o_q   <= '0;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            buf_q      <= buf_d;
            buf_full_q <= buf_full_d;
            prev_q     <= prev_d;
            curr_q     <= curr_d;
            phase_q    <= phase_d;
            data_o_q   <= data_o_d;
            underrun_q <= underrun_d;
        end
    end

    assign in_ready = !buf_full_q;
    assign data_o   = data_o_q;
    assign underrun = underrun_q;

endmodule
